// File: rtl/cu_vertex_data_unpack_module_pkg.sv
// rtl/cu_vertex_data_unpack_module_pkg.sv - CU-wide cacheline geometry, response/data/edge types and endianness helper
package cu_vertex_data_unpack_module_pkg;

  localparam int CACHELINE_SIZE         = 64;
  localparam int CACHELINE_SIZE_BITS    = CACHELINE_SIZE * 8;
  localparam int CACHELINE_SIZE_BITS_HF = CACHELINE_SIZE_BITS / 2;
  localparam int DATA_SIZE_READ         = 4;
  localparam int DATA_SIZE_READ_BITS    = DATA_SIZE_READ * 8;

  typedef struct packed {
    logic [7:0]  cu_id_x;
    logic [7:0]  cu_id_y;
    logic [31:0] address_offset;
  } CommandTagLine;

  typedef struct packed {
    CommandTagLine cmd;
    logic [1:0]    response;
  } ResponsePayload;

  typedef struct packed {
    logic           valid;
    ResponsePayload payload;
  } ResponseBufferLine;

  typedef struct packed {
    logic                              valid;
    logic [CACHELINE_SIZE_BITS_HF-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic                           valid;
    logic [7:0]                     cu_id_x;
    logic [7:0]                     cu_id_y;
    logic [DATA_SIZE_READ_BITS-1:0] data;
  } EdgeDataRead;

  function automatic logic [DATA_SIZE_READ_BITS-1:0] swap_endianness_data_read(
    input logic [DATA_SIZE_READ_BITS-1:0] d
  );
    logic [DATA_SIZE_READ_BITS-1:0] r;
    for (int b = 0; b < DATA_SIZE_READ; b++) begin
      r[8*b +: 8] = d[8*(DATA_SIZE_READ-1-b) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cu_vertex_data_unpack_module_fifo.sv
// rtl/cu_vertex_data_unpack_module_fifo.sv - first-word-fall-through FIFO with occupancy count
module cu_vertex_data_unpack_module_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cu_vertex_data_unpack_module.sv
// rtl/cu_vertex_data_unpack_module.sv - pairs read responses with data beats and emits one swapped vertex value per line
module cu_vertex_data_unpack_module
  import cu_vertex_data_unpack_module_pkg::*;
#(
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  ResponseBufferLine read_response_in,
  input  ReadWriteDataLine  read_data_0_in,
  input  ReadWriteDataLine  read_data_1_in,
  input  logic              edge_data_ready_in,
  output EdgeDataRead       edge_data_out,
  output logic              almost_full_out,
  output logic              overflow_error_out
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OFF_LSB = $clog2(DATA_SIZE_READ);
  localparam int OFF_MSB = $clog2(CACHELINE_SIZE) - 1;
  localparam int IDX_W   = OFF_MSB - OFF_LSB + 1;
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  typedef enum logic {IDLE, OUT} state_t;

  state_t            state;
  state_t            next_state;
  logic              rstn_internal;
  logic              enabled;
  ResponseBufferLine rsp_reg;
  ReadWriteDataLine  d0_reg;
  ReadWriteDataLine  d1_reg;

  ResponsePayload                    rsp_head;
  logic [CACHELINE_SIZE_BITS_HF-1:0] d0_head;
  logic [CACHELINE_SIZE_BITS_HF-1:0] d1_head;
  logic                              rsp_full, d0_full, d1_full;
  logic                              rsp_empty, d0_empty, d1_empty;
  logic [CNT_W-1:0]                  rsp_count, d0_count, d1_count;

  logic                              triple_ready;
  logic                              pop_triple;
  logic [IDX_W-1:0]                  idx;
  logic [IDX_W-2:0]                  word_sel;
  logic [CACHELINE_SIZE_BITS_HF-1:0] half;
  logic [DATA_SIZE_READ_BITS-1:0]    word;
  EdgeDataRead                       packet_next;
  logic                              unused_bits;

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      rstn_internal <= 1'b0;
    end else begin
      rstn_internal <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal) begin
      enabled <= 1'b0;
      rsp_reg <= '0;
      d0_reg  <= '0;
      d1_reg  <= '0;
    end else begin
      enabled <= enabled_in;
      rsp_reg <= read_response_in;
      d0_reg  <= read_data_0_in;
      d1_reg  <= read_data_1_in;
    end
  end

  cu_vertex_data_unpack_module_fifo #(.WIDTH($bits(ResponsePayload)), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clock(clock), .rstn(rstn_internal), .push(rsp_reg.valid), .pop(pop_triple),
    .data_in(rsp_reg.payload), .data_out(rsp_head), .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );

  cu_vertex_data_unpack_module_fifo #(.WIDTH(CACHELINE_SIZE_BITS_HF), .DEPTH(FIFO_DEPTH)) u_d0_fifo (
    .clock(clock), .rstn(rstn_internal), .push(d0_reg.valid), .pop(pop_triple),
    .data_in(d0_reg.data), .data_out(d0_head), .full(d0_full), .empty(d0_empty), .count(d0_count)
  );

  cu_vertex_data_unpack_module_fifo #(.WIDTH(CACHELINE_SIZE_BITS_HF), .DEPTH(FIFO_DEPTH)) u_d1_fifo (
    .clock(clock), .rstn(rstn_internal), .push(d1_reg.valid), .pop(pop_triple),
    .data_in(d1_reg.data), .data_out(d1_head), .full(d1_full), .empty(d1_empty), .count(d1_count)
  );

  // Word index within the line: top bit picks the half, the rest pick the word in it.
  always_comb begin
    idx      = rsp_head.cmd.address_offset[OFF_MSB:OFF_LSB];
    word_sel = idx[IDX_W-2:0];
    half     = idx[IDX_W-1] ? d1_head : d0_head;
    word     = half[DATA_SIZE_READ_BITS*word_sel +: DATA_SIZE_READ_BITS];

    packet_next         = '0;
    packet_next.valid   = 1'b1;
    packet_next.cu_id_x = rsp_head.cmd.cu_id_x;
    packet_next.cu_id_y = rsp_head.cmd.cu_id_y;
    packet_next.data    = swap_endianness_data_read(word);
  end

  assign unused_bits = ^{rsp_head.response,
                         rsp_head.cmd.address_offset[31:OFF_MSB+1],
                         rsp_head.cmd.address_offset[OFF_LSB-1:0]};

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    triple_ready = enabled && !rsp_empty && !d0_empty && !d1_empty;
    pop_triple   = 1'b0;
    next_state   = state;
    case (state)
      IDLE: begin
        if (triple_ready) begin
          pop_triple = 1'b1;
          next_state = OUT;
        end
      end
      OUT: begin
        if (edge_data_ready_in) begin
          if (triple_ready) begin
            pop_triple = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal) begin
      edge_data_out      <= '0;
      almost_full_out    <= 1'b0;
      overflow_error_out <= 1'b0;
    end else begin
      if (pop_triple) begin
        edge_data_out <= packet_next;
      end else if (state == OUT && edge_data_ready_in) begin
        edge_data_out <= '0;
      end
      almost_full_out <= (rsp_count >= AF_LEVEL) || (d0_count >= AF_LEVEL) || (d1_count >= AF_LEVEL);
      overflow_error_out <= overflow_error_out
                          || (rsp_reg.valid && rsp_full && !pop_triple)
                          || (d0_reg.valid && d0_full && !pop_triple)
                          || (d1_reg.valid && d1_full && !pop_triple);
    end
  end

endmodule
